// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address and control sequencer for one shared radix-2 DIT butterfly
// working in place on an N-point sample RAM whose input is already in bit-reversed order.
// One butterfly is issued per RUN cycle; a single DRAIN bubble closes each stage so the
// last write-back of a stage lands before the first read of the next.
//
// Optional build macro: FFT_SEQ_IFFT_EN adds the `inverse` input (latched on start
// acceptance) and the `tw_conj` output (latched value while busy, 0 otherwise).
module fft_stage_sequencer #(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned LOG2_N   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
`ifdef FFT_SEQ_IFFT_EN
    input  logic                      inverse,
    output logic                      tw_conj,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [LOG2_N-1:0]         rd_addr_a,
    output logic [LOG2_N-1:0]         rd_addr_b,
    output logic                      rd_en,
    output logic [LOG2_N-2:0]         tw_addr,
    output logic                      wr_en,
    output logic [LOG2_N-1:0]         wr_addr_a,
    output logic [LOG2_N-1:0]         wr_addr_b,
    output logic [$clog2(LOG2_N)-1:0] stage,
    output logic                      first_stage
);

    localparam int unsigned SW = $clog2(LOG2_N);  // stage counter width
    localparam int unsigned JW = LOG2_N - 1;      // butterfly counter width

    localparam logic [JW-1:0] JLast = JW'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0] SLast = SW'(LOG2_N - 1);
    // One extra bit so s+1 and (LOG2_N-1-s) never overflow the shift amount.
    localparam logic [SW:0]   TwTop = (SW + 1)'(LOG2_N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [JW-1:0]   j_q, j_d;

    logic            run;
    logic [SW:0]     s_ext;
    logic [SW:0]     s_p1;
    logic [SW:0]     tw_sh;
    logic [LOG2_N-1:0] j_ext;
    logic [LOG2_N-1:0] half;
    logic [LOG2_N-1:0] pos;
    logic [LOG2_N-1:0] grp;
    logic [LOG2_N-1:0] addr_a_c;
    logic [LOG2_N-1:0] addr_b_c;
    logic [JW-1:0]     tw_c;

    logic [LOG2_N-1:0] hold_a_q;
    logic [LOG2_N-1:0] hold_b_q;
    logic [JW-1:0]     hold_tw_q;

    logic              wr_en_q;
    logic [LOG2_N-1:0] wr_a_q;
    logic [LOG2_N-1:0] wr_b_q;
    logic [SW-1:0]     stage_q;
    logic              first_q;

    // State and loop-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
        end
    end

    // Next-state logic: N/2 RUN cycles then one DRAIN per stage, LOG2_N stages, then DONE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            StRun: begin
                if (j_q == JLast) begin
                    state_d = StDrain;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDrain: begin
                if (s_q == SLast) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                    s_d     = s_q + 1'b1;
                    j_d     = '0;
                end
            end
            StDone: begin
                // Clear the counters so the idle write-back copies read as stage 0.
                state_d = StIdle;
                s_d     = '0;
                j_d     = '0;
            end
            default: begin
                state_d = StIdle;
                s_d     = '0;
                j_d     = '0;
            end
        endcase
    end

    // Status strobes decoded straight from the state register.
    always_comb begin
        run   = (state_q == StRun);
        busy  = (state_q != StIdle);
        done  = (state_q == StDone);
        rd_en = run;
    end

    // Butterfly operand addresses: insert a 0 at bit s of j for the even operand,
    // the odd operand is the same index with bit s set. Twiddle index is the
    // in-group position scaled up to the N/2-entry ROM.
    always_comb begin
        s_ext    = {1'b0, s_q};
        s_p1     = s_ext + 1'b1;
        tw_sh    = TwTop - s_ext;
        j_ext    = {1'b0, j_q};
        half     = LOG2_N'(1) << s_q;
        pos      = j_ext & (half - 1'b1);
        grp      = j_ext >> s_q;
        addr_a_c = (grp << s_p1) | pos;
        // Bit s of addr_a_c is always 0, so the add never carries.
        addr_b_c = addr_a_c + half;
        tw_c     = pos[JW-1:0] << tw_sh;
    end

    // Last issued read addresses, presented while no read is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            hold_tw_q <= '0;
        end else if (run) begin
            hold_a_q  <= addr_a_c;
            hold_b_q  <= addr_b_c;
            hold_tw_q <= tw_c;
        end
    end

    // Read-side address outputs: live during RUN, held otherwise.
    always_comb begin
        rd_addr_a = run ? addr_a_c : hold_a_q;
        rd_addr_b = run ? addr_b_c : hold_b_q;
        tw_addr   = run ? tw_c     : hold_tw_q;
    end

    // Write-back pipeline: one cycle behind the read, aligned with RAM/ROM output data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            wr_a_q  <= '0;
            wr_b_q  <= '0;
            stage_q <= '0;
            first_q <= 1'b0;
        end else begin
            wr_en_q <= run;
            wr_a_q  <= rd_addr_a;
            wr_b_q  <= rd_addr_b;
            stage_q <= s_q;
            // Only qualify base-case mode on real write-backs of stage 0.
            first_q <= run && (s_q == '0);
        end
    end

    // Write-side outputs.
    always_comb begin
        wr_en       = wr_en_q;
        wr_addr_a   = wr_a_q;
        wr_addr_b   = wr_b_q;
        stage       = stage_q;
        first_stage = first_q;
    end

`ifdef FFT_SEQ_IFFT_EN
    logic inv_q;

    // Direction latched when a transform is accepted; held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            inv_q <= inverse;
        end
    end

    // Conjugate twiddles only while a transform is in flight.
    always_comb begin
        tw_conj = busy && inv_q;
    end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at N=8: a cycle-index reference model,
// literal address tables, an impulse run through a behavioural RAM + butterfly,
// directed corner cases and a randomized start/reset phase.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

    localparam int N     = 8;
    localparam int LG    = 3;
    localparam int AW    = LG;
    localparam int TW    = LG - 1;
    localparam int SW    = $clog2(LG);
    localparam int HALFN = N / 2;
    localparam int SLOT  = HALFN + 1;
    localparam int LAT   = LG * SLOT + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done, rd_en, wr_en, first_stage;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [TW-1:0] tw_addr;
    logic [SW-1:0] stage;
`ifdef FFT_SEQ_IFFT_EN
    logic inverse = 1'b0;
    logic tw_conj;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(
        .N_POINTS(N),
        .LOG2_N  (LG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef FFT_SEQ_IFFT_EN
        .inverse    (inverse),
        .tw_conj    (tw_conj),
`endif
        .busy       (busy),
        .done       (done),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_en      (rd_en),
        .tw_addr    (tw_addr),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .stage      (stage),
        .first_stage(first_stage)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what happens in cycle t after acceptance (0 = idle).
    function automatic void slot(input int t, output bit rd, output int s, output int a,
                                 output int b, output int tw);
        int k, r, half;
        rd = 0; s = 0; a = 0; b = 0; tw = 0;
        if (t > 0) begin
            k = t - 1;
            s = k / SLOT;
            r = k % SLOT;
            if (s >= LG) begin
                s = LG - 1;
            end else if (r < HALFN) begin
                rd   = 1;
                half = 1 << s;
                a    = (r / half) * 2 * half + r % half;
                b    = a + half;
                tw   = (r % half) * (HALFN / half);
            end
        end
    endfunction

    int m_t = 0;
    logic [AW-1:0] m_ha = '0, m_hb = '0, m_wa = '0, m_wb = '0;
    logic [TW-1:0] m_htw = '0;
    logic m_wen = 1'b0, m_first = 1'b0, m_inv = 1'b0;
    int m_stage = 0;
    bit cur_rd;
    int cur_s, cur_a, cur_b, cur_tw;

    always_comb begin
        cur_rd = 0; cur_s = 0; cur_a = 0; cur_b = 0; cur_tw = 0;
        slot(m_t, cur_rd, cur_s, cur_a, cur_b, cur_tw);
    end

    // Model state advance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_ha <= '0; m_hb <= '0; m_htw <= '0;
            m_wen <= 1'b0; m_wa <= '0; m_wb <= '0; m_stage <= 0; m_first <= 1'b0;
            m_inv <= 1'b0;
        end else begin
            m_wen   <= cur_rd;
            m_wa    <= cur_rd ? AW'(cur_a) : m_ha;
            m_wb    <= cur_rd ? AW'(cur_b) : m_hb;
            m_stage <= cur_s;
            m_first <= cur_rd && (cur_s == 0);
            if (cur_rd) begin
                m_ha  <= AW'(cur_a);
                m_hb  <= AW'(cur_b);
                m_htw <= TW'(cur_tw);
            end
            if (m_t == 0) begin
                if (start) begin
                    m_t <= 1;
`ifdef FFT_SEQ_IFFT_EN
                    m_inv <= inverse;
`endif
                end
            end else if (m_t == LAT) begin
                m_t <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, int'(m_t > 0));
            check("done", done, int'(m_t == LAT));
            check("rd_en", rd_en, int'(cur_rd));
            check("rd_addr_a", rd_addr_a, cur_rd ? cur_a : int'(m_ha));
            check("rd_addr_b", rd_addr_b, cur_rd ? cur_b : int'(m_hb));
            check("tw_addr", tw_addr, cur_rd ? cur_tw : int'(m_htw));
            check("wr_en", wr_en, m_wen);
            check("wr_addr_a", wr_addr_a, m_wa);
            check("wr_addr_b", wr_addr_b, m_wb);
            check("stage", stage, m_stage);
            check("first_stage", first_stage, m_first);
`ifdef FFT_SEQ_IFFT_EN
            check("tw_conj", tw_conj, int'((m_t > 0) && m_inv));
`endif
        end
    end

    // Behavioural sample RAM, twiddle ROM (Q8, W^k = exp(-j*2*pi*k/8)) and butterfly.
    int ram_re[N], ram_im[N];
    int ra_re = 0, ra_im = 0, rb_re = 0, rb_im = 0, tw_k = 0;
    int w_re[4] = '{256, 181, 0, -181};
    int w_im[4] = '{0, -181, -256, -181};
    int bf_pr, bf_pi;
    logic ram_clr = 1'b0;

    always_comb begin
        bf_pr = (w_re[tw_k] * rb_re - w_im[tw_k] * rb_im) >>> 8;
        bf_pi = (w_re[tw_k] * rb_im + w_im[tw_k] * rb_re) >>> 8;
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < N; i++) begin
                ram_re[i] <= 0;
                ram_im[i] <= 0;
            end
            ram_re[0] <= 1000;
        end else begin
            if (wr_en) begin
                ram_re[wr_addr_a] <= ra_re + bf_pr;
                ram_im[wr_addr_a] <= ra_im + bf_pi;
                ram_re[wr_addr_b] <= ra_re - bf_pr;
                ram_im[wr_addr_b] <= ra_im - bf_pi;
            end
            if (rd_en) begin
                ra_re <= ram_re[rd_addr_a];
                ra_im <= ram_im[rd_addr_a];
                rb_re <= ram_re[rd_addr_b];
                rb_im <= ram_im[rd_addr_b];
                tw_k  <= int'(tw_addr);
            end
        end
    end

    int lit_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    initial begin
        int r, st, idx, ndone, donet, cyc;

        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset with no start.
        repeat (20) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_rd_en", rd_en, 0);
            check("idle_rd_addr_b", rd_addr_b, 0);
            check("idle_first_stage", first_stage, 0);
        end

        // Impulse transform with literal address sequence.
        @(posedge clk); #1 ram_clr = 1'b1;
        @(posedge clk); #1 ram_clr = 1'b0;
        start = 1'b1;
`ifdef FFT_SEQ_IFFT_EN
        inverse = 1'b1;
`endif
        @(posedge clk); #1 start = 1'b0;
`ifdef FFT_SEQ_IFFT_EN
        inverse = 1'b0;
`endif
        for (int t = 1; t <= LAT + 1; t++) begin
            @(negedge clk);
            r  = (t - 1) % SLOT;
            st = (t - 1) / SLOT;
            if (t < LAT && r < HALFN) begin
                idx = st * HALFN + r;
                check("lit_rd_en", rd_en, 1);
                check("lit_rd_a", rd_addr_a, lit_a[idx]);
                check("lit_rd_b", rd_addr_b, lit_b[idx]);
                check("lit_tw", tw_addr, lit_tw[idx]);
            end
            check("lit_done", done, int'(t == LAT));
            check("lit_first_stage", first_stage, int'(t >= 2 && t <= 5));
`ifdef FFT_SEQ_IFFT_EN
            check("lit_tw_conj", tw_conj, int'(t <= LAT));
`endif
        end
        for (int i = 0; i < N; i++) begin
            check("bin_re", ram_re[i], 1000);
            check("bin_im", ram_im[i], 0);
        end

        // Start re-pulsed while busy is ignored.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0;
        donet = 0;
        for (int t = 1; t <= 25; t++) begin
            start = (t == 7);
            @(negedge clk);
            if (done) begin
                ndone++;
                donet = t;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_start_done_count", ndone, 1);
        check("busy_start_done_cycle", donet, LAT);

        // Reset in the middle of a transform, then a clean rerun.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_rd_addr_b", rd_addr_b, 0);
        check("midrst_stage", stage, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        while (cyc <= 40) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
            cyc++;
        end
        check("rerun_done_cycle", cyc, LAT);
        @(posedge clk); #1;

        // Randomized starts, direction and occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
`ifdef FFT_SEQ_IFFT_EN
            inverse = 1'($urandom_range(0, 1));
`endif
            rst_n = ($urandom_range(0, 249) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences one shared radix-2 butterfly (FFT_Calc) over an in-place N-point sample RAM.
- Runs log2(N) decimation-in-time stages of N/2 butterflies each, at one butterfly per cycle.
- Generates RAM read and write addresses, the twiddle ROM index, the stage number and a first-stage flag that selects base-case versus scaled butterfly mode.
- Sits between the frame loader, which has already written the input in bit-reversed order, and the spectrum readout logic.

Parameters:
- N_POINTS, 64, FFT length; must be a power of two, minimum 4.
- LOG2_N, 6, log2(N_POINTS); sets the address width and the stage count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- busy  out  1  high from RUN entry until DONE exit
- done  out  1  single-cycle pulse when the transform is complete
- rd_addr_a  out  LOG2_N  even-operand read address
- rd_addr_b  out  LOG2_N  odd-operand read address
- rd_en  out  1  read strobe; the RAM returns data one cycle later
- tw_addr  out  LOG2_N-1  twiddle ROM index; ROM has 1-cycle latency, aligned with the read data
- wr_en  out  1  write-back strobe for butterfly results
- wr_addr_a  out  LOG2_N  sum_term destination address
- wr_addr_b  out  LOG2_N  diff_term destination address
- stage  out  $clog2(LOG2_N)  stage of the butterfly currently being written back
- first_stage  out  1  high when the written-back butterfly belongs to stage 0 (base-case butterfly mode)

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset is asynchronous and may occur at any time, including mid-transform; an in-flight write is dropped and RAM contents are undefined.
- States and transitions:
  - IDLE: start=1 -> RUN, with s=0 and j=0.
  - RUN: issues one butterfly per cycle. When j = N/2-1 -> DRAIN.
  - DRAIN: one bubble cycle; the last butterfly of the stage writes back here. If s < LOG2_N-1 -> RUN with s+1 and j=0; otherwise -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE. A start held continuously re-triggers from IDLE, so the transforms run back to back with one IDLE cycle between them.
- Address generation for stage s and butterfly j:
  - half = 1<<s
  - pos = j & (half-1)
  - grp = j>>s
  - rd_addr_a = (grp<<(s+1)) | pos
  - rd_addr_b = rd_addr_a + half
  - tw_addr = pos << (LOG2_N-1-s)
- rd_en=1 in every RUN cycle, 0 otherwise. The address outputs are combinational from the counters and are held at the last value when rd_en=0.
- Write-back path:
  - wr_en, wr_addr_a/b, stage and first_stage are the 1-cycle registered copies of rd_en, rd_addr_a/b, s and (s==0).
  - The butterfly is combinational between the RAM/ROM outputs and the RAM write port.
- The DRAIN bubble guarantees that the first read of stage s+1 never precedes the last write of stage s. Within a stage, all addresses are disjoint.
- Latency: with the start-accept edge counted as cycle 0, done is high in cycle LOG2_N*(N/2+1)+1. busy is high from cycle 1 through that cycle inclusive.
- Width rules: counters are unsigned and wrap is never reached, because the state transitions reset them. tw_addr never exceeds N/2-1.

Optional Feature:
- Macro: FFT_SEQ_IFFT_EN.
- When defined:
  - Adds the input port inverse (1 bit), latched on start acceptance.
  - Adds the output port tw_conj (1 bit), which equals the latched value for the whole of busy and is 0 otherwise. Downstream logic negates twiddle_imag when tw_conj=1 to compute the inverse transform.
- When not defined: neither port exists and behaviour is identical in every other respect.

Test Plan:
- Reset and idle: rst_n low, then released, no start -> all outputs 0 and state stays IDLE for 20 cycles.
- Address sequence, N=8: start pulse -> the rd pairs and tw_addr values below are observed, with each write pair appearing one cycle after its read pair.
  - Cycles 1-4: (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - Cycle 5: DRAIN.
  - Cycles 6-9: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - Cycle 10: DRAIN.
  - Cycles 11-14: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
  - Cycle 15: DRAIN.
  - Cycle 16: done.
- End-to-end with FFT_Calc, N=8: input 1,0,0,0,0,0,0,0 (real) -> all 8 bins equal the same value, and first_stage is high only for the writes in cycles 2-5.
- Start while busy: pulse start at cycles 0 and 7 -> a single transform runs and done pulses once, at cycle 16.
- Mid-run reset: assert rst_n at cycle 8 -> all outputs go to 0 immediately. A subsequent start gives a full 16-cycle run beginning at stage 0.
- FFT_SEQ_IFFT_EN build: start with inverse=1, then drop inverse -> tw_conj stays 1 for cycles 1-16 and is 0 in cycle 17.
